// File: rtl/cg_rvarch_decode_stage_if.sv
// Upstream/downstream handshake and decoded-field bundle for the RISC-V decode stage.
// The master side is the environment (fetch plus consumer); the slave side is the stage itself.
interface cg_rvarch_decode_stage_if #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = XLEN
);
   logic                i_flush;
   logic                i_valid;
   logic                o_ready;
   logic [31:0]         i_instr;
   logic [PC_WIDTH-1:0] i_pc;
   logic                o_valid;
   logic                i_ready;
   logic [PC_WIDTH-1:0] o_pc;
   logic [6:0]          o_opcode;
   logic [4:0]          o_rd;
   logic [4:0]          o_rs1;
   logic [4:0]          o_rs2;
   logic [2:0]          o_funct3;
   logic [6:0]          o_funct7;
   logic [XLEN-1:0]     o_imm;
   logic                o_rd_we;
   logic                o_is_branch;
   logic                o_illegal;

   modport master (
      output i_flush, i_valid, i_instr, i_pc, i_ready,
      input  o_ready, o_valid, o_pc, o_opcode, o_rd, o_rs1, o_rs2,
             o_funct3, o_funct7, o_imm, o_rd_we, o_is_branch, o_illegal
   );

   modport slave (
      input  i_flush, i_valid, i_instr, i_pc, i_ready,
      output o_ready, o_valid, o_pc, o_opcode, o_rd, o_rs1, o_rs2,
             o_funct3, o_funct7, o_imm, o_rd_we, o_is_branch, o_illegal
   );
endinterface

// File: rtl/cg_rvarch_decode_stage.sv
// Registered RV32/RV64 instruction decode stage behind a two-entry skid FIFO.
// Instructions are decoded on entry, so the FIFO holds fully decoded bundles.
module cg_rvarch_decode_stage #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = XLEN
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   cg_rvarch_decode_stage_if.slave   io_bus
);

   if (!(XLEN == 32 || XLEN == 64)) begin : g_badXlen
      $error("cg_rvarch_decode_stage: XLEN must be 32 or 64");
   end

   localparam bit IS_RV64 = (XLEN == 64);

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stateT;

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [XLEN-1:0]     imm;
      logic [6:0]          opcode;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic                rdWe;
      logic                isBranch;
      logic                illegal;
   } entryT;

   stateT       r_state;
   stateT       w_nextState;
   logic        r_ready;
   entryT       r_head;
   entryT       r_tail;
   entryT       w_decoded;
   logic [31:0] w_instr;
   logic [31:0] w_imm32;
   logic        w_legal;
   logic        w_writer;
   logic        w_push;
   logic        w_pop;
   logic        w_loadHeadIn;
   logic        w_loadHeadTail;
   logic        w_loadTail;

   assign w_instr = io_bus.i_instr;

   // Immediates are formed at 32 bits and sign-extended to XLEN afterwards.
   always_comb begin
      w_imm32  = '0;
      w_legal  = 1'b0;
      w_writer = 1'b0;
      case (w_instr[6:0])
         OPC_LUI, OPC_AUIPC: begin
            w_imm32  = {w_instr[31:12], 12'h000};
            w_legal  = 1'b1;
            w_writer = 1'b1;
         end
         OPC_JAL: begin
            w_imm32  = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
            w_legal  = 1'b1;
            w_writer = 1'b1;
         end
         OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
            w_imm32  = {{20{w_instr[31]}}, w_instr[31:20]};
            w_legal  = 1'b1;
            w_writer = 1'b1;
         end
         OPC_OP_IMM_32: begin
            w_imm32  = {{20{w_instr[31]}}, w_instr[31:20]};
            w_legal  = IS_RV64;
            w_writer = IS_RV64;
         end
         OPC_STORE: begin
            w_imm32  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            w_legal  = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm32  = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
            w_legal  = 1'b1;
         end
         OPC_OP: begin
            w_legal  = 1'b1;
            w_writer = 1'b1;
         end
         OPC_OP_32: begin
            w_legal  = IS_RV64;
            w_writer = IS_RV64;
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            w_legal  = 1'b1;
         end
         default: begin
            w_legal  = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_decoded          = '0;
      w_decoded.pc       = io_bus.i_pc;
      w_decoded.imm      = XLEN'($signed(w_imm32));
      w_decoded.opcode   = w_instr[6:0];
      w_decoded.rd       = w_instr[11:7];
      w_decoded.funct3   = w_instr[14:12];
      w_decoded.rs1      = w_instr[19:15];
      w_decoded.rs2      = w_instr[24:20];
      w_decoded.funct7   = w_instr[31:25];
      w_decoded.rdWe     = w_writer && (w_instr[11:7] != 5'd0);
      w_decoded.isBranch = (w_instr[6:0] == OPC_BRANCH);
      w_decoded.illegal  = !w_legal;
   end

   assign w_push = io_bus.i_valid && r_ready;
   assign w_pop  = (r_state != ST_EMPTY) && io_bus.i_ready;

   // Occupancy FSM; at one entry a simultaneous push and pop replaces the head in place.
   always_comb begin
      w_nextState    = r_state;
      w_loadHeadIn   = 1'b0;
      w_loadHeadTail = 1'b0;
      w_loadTail     = 1'b0;
      if (io_bus.i_flush) begin
         w_nextState = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_loadHeadIn = 1'b1;
                  w_nextState  = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  w_loadHeadIn = 1'b1;
               end else if (w_push) begin
                  w_loadTail  = 1'b1;
                  w_nextState = ST_FULL;
               end else if (w_pop) begin
                  w_nextState = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  w_loadHeadTail = 1'b1;
                  w_nextState    = ST_ONE;
               end
            end
            default: begin
               w_nextState = ST_EMPTY;
            end
         endcase
      end
   end

   // Ready is registered from the next occupancy so it never depends on i_ready combinationally.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_EMPTY;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_ready <= (w_nextState != ST_FULL);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_loadHeadIn) begin
            r_head <= w_decoded;
         end else if (w_loadHeadTail) begin
            r_head <= r_tail;
         end
         if (w_loadTail) begin
            r_tail <= w_decoded;
         end
      end
   end

   assign io_bus.o_ready     = r_ready;
   assign io_bus.o_valid     = (r_state != ST_EMPTY);
   assign io_bus.o_pc        = r_head.pc;
   assign io_bus.o_imm       = r_head.imm;
   assign io_bus.o_opcode    = r_head.opcode;
   assign io_bus.o_rd        = r_head.rd;
   assign io_bus.o_rs1       = r_head.rs1;
   assign io_bus.o_rs2       = r_head.rs2;
   assign io_bus.o_funct3    = r_head.funct3;
   assign io_bus.o_funct7    = r_head.funct7;
   assign io_bus.o_rd_we     = r_head.rdWe;
   assign io_bus.o_is_branch = r_head.isBranch;
   assign io_bus.o_illegal   = r_head.illegal;

endmodule

// File: tb/tb_cg_rvarch_decode_stage.sv
// Drives an RV32 and an RV64 instance of the decode stage with identical traffic and
// checks both against a reference decoder feeding per-instance expectation queues.
module tb_cg_rvarch_decode_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] imm;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic        rdWe;
      logic        isBranch;
      logic        illegal;
   } expT;

   localparam logic [31:0] INSTR_TBL [16] = '{
      32'hFFF00093, 32'h123452B7, 32'hFE000EE3, 32'h0000001B,
      32'h003100BB, 32'h00112423, 32'h008000EF, 32'h000080E7,
      32'h00412083, 32'h00000001, 32'h00000073, 32'h0000000F,
      32'h002081B3, 32'hFFFFF117, 32'h0000007F, 32'h80000463
   };

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] curInstr;
   logic [63:0] curPc;
   int          nCompared = 0;
   int          nMismatch = 0;
   int          cyc = 0;
   expT         sb[2][$];

   cg_rvarch_decode_stage_if #(.XLEN(32)) bus32 ();
   cg_rvarch_decode_stage_if #(.XLEN(64)) bus64 ();

   cg_rvarch_decode_stage #(.XLEN(32)) u_dut32 (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .io_bus  (bus32.slave)
   );

   cg_rvarch_decode_stage #(.XLEN(64)) u_dut64 (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .io_bus  (bus64.slave)
   );

   always #5 clk = ~clk;

   // Edges seen since the last reset release; o_ready may only rise after the first one.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) cyc <= 0;
      else if (cyc < 2) cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkEntry(input string tag, input expT obs, input expT exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [63:0] pc,
                                input logic ready, input logic flush);
      curInstr      = instr;
      curPc         = pc;
      bus32.i_valid = valid;
      bus64.i_valid = valid;
      bus32.i_instr = instr;
      bus64.i_instr = instr;
      bus32.i_pc    = pc[31:0];
      bus64.i_pc    = pc;
      bus32.i_ready = ready;
      bus64.i_ready = ready;
      bus32.i_flush = flush;
      bus64.i_flush = flush;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic expT model(input logic [31:0] ins, input logic [63:0] pc, input bit rv64);
      expT         e;
      logic [6:0]  opc;
      logic [63:0] immI, immS, immB, immU, immJ;
      bit          legal, writer;
      opc  = ins[6:0];
      immI = {{52{ins[31]}}, ins[31:20]};
      immS = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      immB = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      immU = {{32{ins[31]}}, ins[31:12], 12'h000};
      immJ = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      e        = '0;
      e.pc     = rv64 ? pc : {32'h0, pc[31:0]};
      e.opcode = opc;
      e.rd     = ins[11:7];
      e.funct3 = ins[14:12];
      e.rs1    = ins[19:15];
      e.rs2    = ins[24:20];
      e.funct7 = ins[31:25];
      case (opc)
         7'h37, 7'h17:                e.imm = immU;
         7'h6F:                       e.imm = immJ;
         7'h67, 7'h03, 7'h13, 7'h1B:  e.imm = immI;
         7'h23:                       e.imm = immS;
         7'h63:                       e.imm = immB;
         default:                     e.imm = 64'h0;
      endcase
      if (!rv64) e.imm = {32'h0, e.imm[31:0]};
      legal  = (opc inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73})
               || (rv64 && (opc inside {7'h1B, 7'h3B}));
      writer = (opc inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h6F, 7'h67})
               || (rv64 && (opc inside {7'h1B, 7'h3B}));
      e.illegal  = !legal;
      e.rdWe     = writer && (ins[11:7] != 5'd0);
      e.isBranch = (opc == 7'h63);
      return e;
   endfunction

   function automatic expT obs32();
      expT e;
      e.pc = 64'(bus32.o_pc);       e.imm = 64'(bus32.o_imm);
      e.opcode = bus32.o_opcode;    e.rd = bus32.o_rd;
      e.rs1 = bus32.o_rs1;          e.rs2 = bus32.o_rs2;
      e.funct3 = bus32.o_funct3;    e.funct7 = bus32.o_funct7;
      e.rdWe = bus32.o_rd_we;       e.isBranch = bus32.o_is_branch;
      e.illegal = bus32.o_illegal;
      return e;
   endfunction

   function automatic expT obs64();
      expT e;
      e.pc = bus64.o_pc;            e.imm = bus64.o_imm;
      e.opcode = bus64.o_opcode;    e.rd = bus64.o_rd;
      e.rs1 = bus64.o_rs1;          e.rs2 = bus64.o_rs2;
      e.funct3 = bus64.o_funct3;    e.funct7 = bus64.o_funct7;
      e.rdWe = bus64.o_rd_we;       e.isBranch = bus64.o_is_branch;
      e.illegal = bus64.o_illegal;
      return e;
   endfunction

   // Inputs are stable at the falling edge, so handshakes seen here complete on the next rising edge.
   always @(negedge clk) begin : monitor
      expT obsE;
      expT expE;
      bit  oValid;
      bit  oReady;
      int  depth;
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            oValid = bus32.o_valid;
            oReady = bus32.o_ready;
            obsE   = obs32();
         end else begin
            oValid = bus64.o_valid;
            oReady = bus64.o_ready;
            obsE   = obs64();
         end
         depth = sb[d].size();
         if (!rstN) begin
            sb[d].delete();
            checkOutput(d == 0 ? "rstValid32" : "rstValid64", 64'(oValid), 64'd0);
            checkOutput(d == 0 ? "rstReady32" : "rstReady64", 64'(oReady), 64'd0);
         end else begin
            checkOutput(d == 0 ? "validVsModel32" : "validVsModel64", 64'(oValid), 64'(depth != 0));
            checkOutput(d == 0 ? "readyVsModel32" : "readyVsModel64", 64'(oReady),
                        64'((cyc >= 1) && (depth < 2)));
            if (bus32.i_flush) begin
               sb[d].delete();
            end else begin
               if (oValid && bus32.i_ready) begin
                  checkOutput(d == 0 ? "sbUnderflow32" : "sbUnderflow64", 64'(depth != 0), 64'd1);
                  if (depth != 0) begin
                     expE = sb[d].pop_front();
                     checkEntry(d == 0 ? "entry32" : "entry64", obsE, expE);
                  end
               end
               if (bus32.i_valid && oReady) sb[d].push_back(model(curInstr, curPc, d == 1));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstN = 1'b0;
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

      // Reset: nothing valid, not ready, data outputs cleared.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rstImm64", bus64.o_imm, 64'h0);
      checkOutput("rstPc64", bus64.o_pc, 64'h0);
      checkOutput("rstRd32", 64'(bus32.o_rd), 64'h0);
      #1;
      rstN = 1'b1;
      #1;
      checkOutput("readyBeforeEdge", 64'(bus64.o_ready), 64'd0);
      tick();
      checkOutput("readyAfterRelease", 64'(bus64.o_ready), 64'd1);

      // Single-instruction decodes with latency one.
      applyStimulus(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0);
      tick();
      checkOutput("addiValid", 64'(bus64.o_valid), 64'd1);
      checkOutput("addiRd", 64'(bus64.o_rd), 64'd1);
      checkOutput("addiImm64", bus64.o_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("addiRdWe", 64'(bus64.o_rd_we), 64'd1);
      checkOutput("addiIllegal", 64'(bus64.o_illegal), 64'd0);
      applyStimulus(1'b1, 32'h123452B7, 64'h104, 1'b1, 1'b0);
      tick();
      checkOutput("luiImm32", 64'(bus32.o_imm), 64'h12345000);
      checkOutput("luiRd", 64'(bus32.o_rd), 64'd5);
      applyStimulus(1'b1, 32'hFE000EE3, 64'h108, 1'b1, 1'b0);
      tick();
      checkOutput("beqImm32", 64'(bus32.o_imm), 64'hFFFFFFFC);
      checkOutput("beqBranch", 64'(bus32.o_is_branch), 64'd1);
      checkOutput("beqRdWe", 64'(bus32.o_rd_we), 64'd0);
      applyStimulus(1'b1, 32'h0000001B, 64'h10C, 1'b1, 1'b0);
      tick();
      checkOutput("opImm32Illegal32", 64'(bus32.o_illegal), 64'd1);
      checkOutput("opImm32RdWe32", 64'(bus32.o_rd_we), 64'd0);
      checkOutput("opImm32Illegal64", 64'(bus64.o_illegal), 64'd0);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      tick();

      // Back-pressure: A and B fill the FIFO, C waits until the consumer drains.
      applyStimulus(1'b1, 32'h00412083, 64'h200, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h002081B3, 64'h204, 1'b0, 1'b0);
      tick();
      checkOutput("fullNotReady", 64'(bus64.o_ready), 64'd0);
      applyStimulus(1'b1, 32'h00112423, 64'h208, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("fullStillNotReady", 64'(bus32.o_ready), 64'd0);
      checkOutput("headHeldPc", bus64.o_pc, 64'h200);
      applyStimulus(1'b1, 32'h00112423, 64'h208, 1'b1, 1'b0);
      tick();
      checkOutput("drainPcB", bus64.o_pc, 64'h204);
      tick();
      checkOutput("drainPcC", bus64.o_pc, 64'h208);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      tick();
      checkOutput("drainedValid", 64'(bus64.o_valid), 64'd0);

      // Flush while full with a valid input pending.
      applyStimulus(1'b1, 32'h00000073, 64'h300, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h0000000F, 64'h304, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h008000EF, 64'h308, 1'b1, 1'b1);
      tick();
      checkOutput("flushValid32", 64'(bus32.o_valid), 64'd0);
      checkOutput("flushValid64", 64'(bus64.o_valid), 64'd0);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      tick();
      checkOutput("flushReady", 64'(bus64.o_ready), 64'd1);

      // Mixed random traffic, back-pressure and occasional flushes.
      for (int k = 0; k < 80; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), INSTR_TBL[$urandom_range(0, 15)],
                       {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 15) == 0));
         tick();
      end
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      for (int k = 0; k < 10 && (sb[0].size() != 0 || sb[1].size() != 0); k++) tick();
      checkOutput("noLoss32", 64'(sb[0].size()), 64'd0);
      checkOutput("noLoss64", 64'(sb[1].size()), 64'd0);

      // Asynchronous reset while one entry is buffered.
      applyStimulus(1'b1, 32'h00500093, 64'h400, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
      tick();
      checkOutput("oneBufferedValid", 64'(bus64.o_valid), 64'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("asyncRstValid32", 64'(bus32.o_valid), 64'd0);
      checkOutput("asyncRstValid64", 64'(bus64.o_valid), 64'd0);
      checkOutput("asyncRstReady", 64'(bus64.o_ready), 64'd0);
      @(negedge clk);
      #2;
      rstN = 1'b1;
      #1;
      checkOutput("releaseReadyLow", 64'(bus64.o_ready), 64'd0);
      tick();
      checkOutput("releaseReadyHigh", 64'(bus64.o_ready), 64'd1);
      checkOutput("releaseValid", 64'(bus32.o_valid), 64'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
